alu_pipe: RTL
=============

ALU_PIPE -- requirements
Module: alu_pipe

Interface
REQ-001 SHALL have parameter XLEN, default 32, datapath width (>=8, power of two).
REQ-002 SHALL have parameter TAG_W, default 6, width of the destination tag carried with each op.
REQ-003 SHALL have port CLK  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have port RESET  input  1  synchronous, active-high reset.
REQ-005 SHALL have ports IN_VALID input 1, IN_READY output 1: issue handshake; an op is accepted when both are high on a CLK edge.
REQ-006 SHALL have ports IN_OP input 4, IN_A input XLEN, IN_B input XLEN, IN_TAG input TAG_W: opcode, operands and tag.
REQ-007 SHALL have port FLUSH  input  1  discards the in-flight op and the held result.
REQ-008 SHALL have ports OUT_VALID output 1, OUT_READY input 1: result handshake; a result is consumed when both are high on a CLK edge.
REQ-009 SHALL have ports OUT_RESULT output XLEN, OUT_TAG output TAG_W, OUT_ZERO/OUT_NEG/OUT_CARRY/OUT_OVF/OUT_ILLEGAL output 1 each.

Function
REQ-010 Opcodes SHALL be: 0000 AND, 0001 OR, 0010 ADD, 0011 SUB, 0100 XOR, 0101 MOV (=B), 0110 LUI ({B[XLEN/2-1:0], XLEN/2 zeros}), 0111 SLL, 1000 SRL, 1001 SRA, 1010 MUL (low XLEN bits of A*B, unsigned).
REQ-011 Shift amount SHALL be B[$clog2(XLEN)-1:0]; upper B bits ignored.
REQ-012 Opcodes 1011-1111 SHALL complete in 1 cycle with OUT_RESULT=0, OUT_ILLEGAL=1, all other flags 0.
REQ-013 Single-cycle ops SHALL present the result registered: accepted at edge N, OUT_VALID high after edge N.
REQ-014 MUL SHALL use an iterative shift-add engine, one multiplier bit per cycle; result valid exactly XLEN cycles after acceptance.
REQ-015 FSM states SHALL be IDLE, MUL_BUSY; IDLE->MUL_BUSY on accepted MUL, MUL_BUSY->IDLE on the cycle the MUL result is written to the output register.
REQ-016 IN_READY SHALL be high iff FSM is IDLE and (OUT_VALID is low or OUT_READY is high); back-to-back single-cycle ops SHALL sustain 1 op/cycle when OUT_READY stays high.
REQ-017 A completed MUL SHALL not be written while the output register holds an unconsumed result; the engine stalls in MUL_BUSY until the slot frees.
REQ-018 Output register contents SHALL remain stable while OUT_VALID=1 and OUT_READY=0.
REQ-019 OUT_ZERO SHALL be (OUT_RESULT==0); OUT_NEG SHALL be OUT_RESULT[XLEN-1].
REQ-020 OUT_CARRY SHALL be carry-out for ADD, NOT borrow (A>=B unsigned) for SUB, 0 otherwise.
REQ-021 OUT_OVF SHALL be signed overflow for ADD and SUB, 0 otherwise.
REQ-022 OUT_TAG SHALL equal the IN_TAG accepted with that op.
REQ-023 FLUSH SHALL, on the same edge, clear OUT_VALID, return FSM to IDLE, and ignore IN_VALID; IN_READY is low while FLUSH is high.
REQ-024 Consume and accept on the same edge SHALL load the new single-cycle result with no bubble.

Reset
REQ-025 RESET SHALL set OUT_VALID=0, FSM=IDLE, OUT_RESULT=0, OUT_TAG=0, all flags=0, multiplier registers=0.
REQ-026 RESET mid-MUL SHALL abort the multiply with no result emitted; RESET dominates FLUSH and IN_VALID.
REQ-027 IN_READY SHALL be low during RESET and high on the first cycle after.

Configuration
REQ-028 Macro ALU_PIPE_MUL_EN SHALL, when defined, include the MUL engine and MUL_BUSY state.
REQ-029 Without ALU_PIPE_MUL_EN, opcode 1010 SHALL behave as illegal per REQ-012 and no multiplier logic SHALL be synthesised.

Structure
REQ-030 A shared package alu_pkg SHALL hold the opcode enum/constants, the FSM state typedef, and the flag bundle struct.
REQ-031 The iterative multiplier SHALL be a sub-module alu_mul_iter (start/busy/done handshake, XLEN parameter).

Verification
REQ-032 RESET, then ADD A=0x7FFFFFFF B=1 tag 5 -> one cycle later OUT_RESULT=0x80000000, OVF=1, NEG=1, CARRY=0, TAG=5.
REQ-033 SUB A=3 B=3, then SRA A=0x80000000 B=0x21 back-to-back, OUT_READY=1 -> RESULT=0 ZERO=1 CARRY=1, then 0xC0000000, no bubble.
REQ-034 MUL A=0x10000 B=0x10001 (MUL_EN) -> OUT_VALID exactly 32 cycles after accept, RESULT=0x00010000; IN_READY low throughout.
REQ-035 Hold OUT_READY=0 for 5 cycles with result 0x1234 pending -> result/flags stable, IN_READY low, new op accepted the edge OUT_READY rises.
REQ-036 FLUSH at cycle 10 of a MUL, then RESET during a second MUL -> no OUT_VALID from either; next ADD 1+1 returns 2.
REQ-037 Opcode 1100 A=5 B=6, and 1010 with MUL_EN undefined -> RESULT=0, ILLEGAL=1, latency 1.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared ALU pipeline types: opcode encoding, control FSM states and result flag bundle.
package alu_pkg;

    localparam int unsigned OP_W = 4;

    typedef enum logic [OP_W-1:0] {
        OP_AND = 4'b0000,
        OP_OR  = 4'b0001,
        OP_ADD = 4'b0010,
        OP_SUB = 4'b0011,
        OP_XOR = 4'b0100,
        OP_MOV = 4'b0101,
        OP_LUI = 4'b0110,
        OP_SLL = 4'b0111,
        OP_SRL = 4'b1000,
        OP_SRA = 4'b1001,
        OP_MUL = 4'b1010
    } op_e;

    typedef enum logic {
        ST_IDLE     = 1'b0,
        ST_MUL_BUSY = 1'b1
    } state_e;

    typedef struct packed {
        logic zero;
        logic neg;
        logic carry;
        logic ovf;
        logic illegal;
    } flags_t;

endpackage

// File: rtl/alu_mul_iter.sv
// Iterative shift-add multiplier, one multiplier bit per cycle; the final bit is folded in
// combinationally so the product is available XLEN cycles after start and held until acked.
module alu_mul_iter
    import alu_pkg::*;
#(
    parameter int unsigned XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_start,
    input  logic            i_abort,
    input  logic            i_ack,
    input  logic [XLEN-1:0] i_a,
    input  logic [XLEN-1:0] i_b,
    output logic            o_busy,
    output logic            o_done_c,
    output logic [XLEN-1:0] o_result_c
);

    localparam int unsigned CNT_W = $clog2(XLEN);

    logic             r_busy;
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_mcand;
    logic [XLEN-1:0]  r_mplier;
    logic [XLEN-1:0]  r_acc;
    logic [XLEN-1:0]  w_addend;

    assign w_addend   = r_mplier[0] ? r_mcand : '0;
    assign o_busy     = r_busy;
    assign o_done_c   = r_busy && (r_cnt == CNT_W'(XLEN - 1));
    assign o_result_c = r_acc + w_addend;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_mcand  <= '0;
            r_mplier <= '0;
            r_acc    <= '0;
        end else if (i_abort) begin
            r_busy <= 1'b0;
            r_cnt  <= '0;
        end else if (i_start) begin
            r_busy   <= 1'b1;
            r_cnt    <= '0;
            r_mcand  <= i_a;
            r_mplier <= i_b;
            r_acc    <= '0;
        end else if (r_busy) begin
            // Last bit stays pending until the output slot accepts the product.
            if (!o_done_c) begin
                r_acc    <= r_acc + w_addend;
                r_mcand  <= r_mcand << 1;
                r_mplier <= r_mplier >> 1;
                r_cnt    <= r_cnt + CNT_W'(1);
            end else if (i_ack) begin
                r_busy <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/alu_pipe.sv
// Registered single-issue ALU with valid/ready handshakes, flush and tagged results.
// Define ALU_PIPE_MUL_EN to include the iterative multiplier (opcode MUL) and MUL_BUSY state.
module alu_pipe
    import alu_pkg::*;
#(
    parameter int unsigned XLEN  = 32,
    parameter int unsigned TAG_W = 6
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             IN_VALID,
    output logic             IN_READY,
    input  logic [OP_W-1:0]  IN_OP,
    input  logic [XLEN-1:0]  IN_A,
    input  logic [XLEN-1:0]  IN_B,
    input  logic [TAG_W-1:0] IN_TAG,
    input  logic             FLUSH,
    output logic             OUT_VALID,
    input  logic             OUT_READY,
    output logic [XLEN-1:0]  OUT_RESULT,
    output logic [TAG_W-1:0] OUT_TAG,
    output logic             OUT_ZERO,
    output logic             OUT_NEG,
    output logic             OUT_CARRY,
    output logic             OUT_OVF,
    output logic             OUT_ILLEGAL
);

    localparam int unsigned SHW  = $clog2(XLEN);
    localparam int unsigned HALF = XLEN / 2;

    state_e           r_state;
    logic             r_out_valid;
    logic [XLEN-1:0]  r_result;
    logic [TAG_W-1:0] r_tag;
    flags_t           r_flags;

    logic             w_slot_free;
    logic             w_accept;
    logic             w_is_mul;
    logic [SHW-1:0]   w_shamt;
    logic [XLEN:0]    w_sum;
    logic [XLEN:0]    w_diff;
    logic [XLEN-1:0]  w_res;
    flags_t           w_fl;

    assign w_slot_free = !r_out_valid || OUT_READY;
    assign IN_READY    = !RESET && !FLUSH && (r_state == ST_IDLE) && w_slot_free;
    assign w_accept    = IN_VALID && IN_READY;
    assign w_shamt     = IN_B[SHW-1:0];
    assign w_sum       = {1'b0, IN_A} + {1'b0, IN_B};
    assign w_diff      = {1'b0, IN_A} - {1'b0, IN_B};

    // Single-cycle datapath and flags; illegal opcodes force every other flag low.
    always_comb begin
        w_res    = '0;
        w_fl     = '0;
        w_is_mul = 1'b0;
        case (IN_OP)
            OP_AND: w_res = IN_A & IN_B;
            OP_OR:  w_res = IN_A | IN_B;
            OP_XOR: w_res = IN_A ^ IN_B;
            OP_MOV: w_res = IN_B;
            OP_LUI: w_res = {IN_B[HALF-1:0], {HALF{1'b0}}};
            OP_SLL: w_res = IN_A << w_shamt;
            OP_SRL: w_res = IN_A >> w_shamt;
            OP_SRA: w_res = XLEN'($signed(IN_A) >>> w_shamt);
            OP_ADD: begin
                w_res    = w_sum[XLEN-1:0];
                w_fl.carry = w_sum[XLEN];
                w_fl.ovf   = (IN_A[XLEN-1] == IN_B[XLEN-1]) && (w_sum[XLEN-1] != IN_A[XLEN-1]);
            end
            OP_SUB: begin
                w_res    = w_diff[XLEN-1:0];
                w_fl.carry = !w_diff[XLEN];
                w_fl.ovf   = (IN_A[XLEN-1] != IN_B[XLEN-1]) && (w_diff[XLEN-1] != IN_A[XLEN-1]);
            end
`ifdef ALU_PIPE_MUL_EN
            OP_MUL: w_is_mul = 1'b1;
`endif
            default: w_fl.illegal = 1'b1;
        endcase
        if (!w_fl.illegal) begin
            w_fl.zero = (w_res == '0);
            w_fl.neg  = w_res[XLEN-1];
        end
    end

`ifdef ALU_PIPE_MUL_EN
    logic [TAG_W-1:0] r_mul_tag;
    logic             w_mul_busy;
    logic             w_mul_done;
    logic             w_mul_fire;
    logic [XLEN-1:0]  w_mul_res;
    flags_t           w_mul_fl;

    assign w_mul_fire = (r_state == ST_MUL_BUSY) && w_mul_busy && w_mul_done && w_slot_free;

    always_comb begin
        w_mul_fl      = '0;
        w_mul_fl.zero = (w_mul_res == '0);
        w_mul_fl.neg  = w_mul_res[XLEN-1];
    end

    alu_mul_iter #(
        .XLEN(XLEN)
    ) u_mul (
        .clk        (CLK),
        .rst        (RESET),
        .i_start    (w_accept && w_is_mul),
        .i_abort    (FLUSH),
        .i_ack      (w_mul_fire),
        .i_a        (IN_A),
        .i_b        (IN_B),
        .o_busy     (w_mul_busy),
        .o_done_c   (w_mul_done),
        .o_result_c (w_mul_res)
    );
`endif

    // Control FSM and output register.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
            r_result    <= '0;
            r_tag       <= '0;
            r_flags     <= '0;
`ifdef ALU_PIPE_MUL_EN
            r_mul_tag   <= '0;
`endif
        end else if (FLUSH) begin
            r_state     <= ST_IDLE;
            r_out_valid <= 1'b0;
        end else begin
            if (r_out_valid && OUT_READY) begin
                r_out_valid <= 1'b0;
            end
            if (w_accept && !w_is_mul) begin
                r_out_valid <= 1'b1;
                r_result    <= w_res;
                r_tag       <= IN_TAG;
                r_flags     <= w_fl;
            end
`ifdef ALU_PIPE_MUL_EN
            if (w_accept && w_is_mul) begin
                r_state   <= ST_MUL_BUSY;
                r_mul_tag <= IN_TAG;
            end
            if (w_mul_fire) begin
                r_state     <= ST_IDLE;
                r_out_valid <= 1'b1;
                r_result    <= w_mul_res;
                r_tag       <= r_mul_tag;
                r_flags     <= w_mul_fl;
            end
`endif
        end
    end

    assign OUT_VALID   = r_out_valid;
    assign OUT_RESULT  = r_result;
    assign OUT_TAG     = r_tag;
    assign OUT_ZERO    = r_flags.zero;
    assign OUT_NEG     = r_flags.neg;
    assign OUT_CARRY   = r_flags.carry;
    assign OUT_OVF     = r_flags.ovf;
    assign OUT_ILLEGAL = r_flags.illegal;

endmodule
